// File: rtl/sad_stream_if.sv
// Beat-in / result-out stream bundle for sad_stream_engine.
// slave = engine side, master = producer/consumer side.
interface sad_stream_if #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 4,
  parameter int SUM_W     = 32,
  parameter int WIN_CNT_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] a_data;
  logic [LANES*DATA_W-1:0] b_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SUM_W-1:0]        sad_out;
  logic [WIN_CNT_W-1:0]    win_idx;
  logic [SUM_W-1:0]        min_sad;
  logic [WIN_CNT_W-1:0]    min_idx;

  modport slave (
    input  in_valid, a_data, b_data, out_ready,
    output in_ready, out_valid, sad_out, win_idx, min_sad, min_idx
  );
  modport master (
    output in_valid, a_data, b_data, out_ready,
    input  in_ready, out_valid, sad_out, win_idx, min_sad, min_idx
  );
endinterface

// File: rtl/sad_stream_engine.sv
// Streaming SAD engine: LANES pairs/beat, WIN_LEN beats/window, N windows/job.
// Optional macro SAD_SATURATE_EN: saturating accumulator plus sticky sat_flag.
module sad_stream_engine #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 4,
  parameter int WIN_LEN   = 16,
  parameter int SUM_W     = 32,
  parameter int WIN_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIN_CNT_W-1:0] num_win,
  output logic                 busy,
  output logic                 done,
  sad_stream_if.slave          bus
`ifdef SAD_SATURATE_EN
  ,
  output logic                 sat_flag
`endif
);
  localparam int BEAT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [LANES-1:0][DATA_W-1:0] a_lane, b_lane, diff_q, diff_d;
  logic [WIN_CNT_W-1:0] num_win_q, num_win_d, in_win_q, in_win_d, res_cnt_q, res_cnt_d;
  logic [WIN_CNT_W-1:0] win_idx_q, win_idx_d, min_idx_q, min_idx_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [SUM_W-1:0]     acc_q, acc_d, sad_q, sad_d, min_sad_q, min_sad_d;
  logic [SUM_W-1:0]     lane_sum, base, acc_nxt;
  logic s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic out_valid_q, out_valid_d, done_q, done_d, in_ready;
  logic accept, retire, stall, fire, last_beat, job_end, start_go;
`ifdef SAD_SATURATE_EN
  logic [SUM_W:0] acc_wide;
  logic sat_q, sat_d, ovf;
`endif

  assign a_lane    = bus.a_data;
  assign b_lane    = bus.b_data;
  assign accept    = bus.in_valid && in_ready;
  assign retire    = out_valid_q && bus.out_ready;
  // Only a window-closing beat needs the slot; partial sums keep flowing.
  assign stall     = s1_vld_q && s1_last_q && out_valid_q && !bus.out_ready;
  assign fire      = s1_vld_q && !stall;
  assign last_beat = (beat_q == BEAT_W'(WIN_LEN - 1));
  assign job_end   = accept && last_beat && (in_win_q == num_win_q - WIN_CNT_W'(1));
  assign start_go  = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)                  state_d = RUN;
      RUN:     if (job_end)                state_d = DRAIN;
      DRAIN:   if (retire && !s1_vld_q)    state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    done_d   = (state_q == DRAIN) && retire && !s1_vld_q;
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + SUM_W'(diff_q[i]);
    base = s1_first_q ? '0 : acc_q;
`ifdef SAD_SATURATE_EN
    acc_wide = {1'b0, base} + {1'b0, lane_sum};
    ovf      = acc_wide[SUM_W];
    acc_nxt  = ovf ? '1 : acc_wide[SUM_W-1:0];
`else
    acc_nxt  = base + lane_sum;
`endif
  end

  always_comb begin
    diff_d      = diff_q;
    num_win_d   = num_win_q;
    in_win_d    = in_win_q;
    res_cnt_d   = res_cnt_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
    sad_d       = sad_q;
    win_idx_d   = win_idx_q;
    min_sad_d   = min_sad_q;
    min_idx_d   = min_idx_q;
    s1_vld_d    = s1_vld_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
`ifdef SAD_SATURATE_EN
    sat_d       = sat_q;
`endif
    if (start_go) begin
      num_win_d = (num_win == '0) ? WIN_CNT_W'(1) : num_win;
      in_win_d  = '0;
      res_cnt_d = '0;
      beat_d    = '0;
      win_idx_d = '0;
      min_sad_d = '0;
      min_idx_d = '0;
`ifdef SAD_SATURATE_EN
      sat_d     = 1'b0;
`endif
    end
    if (accept) begin
      for (int i = 0; i < LANES; i++)
        diff_d[i] = (a_lane[i] > b_lane[i]) ? a_lane[i] - b_lane[i] : b_lane[i] - a_lane[i];
      s1_vld_d   = 1'b1;
      s1_first_d = (beat_q == '0);
      s1_last_d  = last_beat;
      beat_d     = last_beat ? '0 : beat_q + BEAT_W'(1);
      if (last_beat) in_win_d = in_win_q + WIN_CNT_W'(1);
    end else if (fire) begin
      s1_vld_d = 1'b0;
    end
    if (retire) out_valid_d = 1'b0;
    if (fire) begin
      acc_d = acc_nxt;
`ifdef SAD_SATURATE_EN
      if (ovf) sat_d = 1'b1;
`endif
      if (s1_last_q) begin
        sad_d       = acc_nxt;
        win_idx_d   = res_cnt_q;
        out_valid_d = 1'b1;
        res_cnt_d   = res_cnt_q + WIN_CNT_W'(1);
        // Strict less-than keeps the earliest window on a tie.
        if (res_cnt_q == '0 || acc_nxt < min_sad_q) begin
          min_sad_d = acc_nxt;
          min_idx_d = res_cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0; num_win_q <= '0; in_win_q <= '0; res_cnt_q <= '0;
      beat_q <= '0; acc_q <= '0; sad_q <= '0; win_idx_q <= '0;
      min_sad_q <= '0; min_idx_q <= '0; s1_vld_q <= 1'b0; s1_first_q <= 1'b0;
      s1_last_q <= 1'b0; out_valid_q <= 1'b0; done_q <= 1'b0;
`ifdef SAD_SATURATE_EN
      sat_q <= 1'b0;
`endif
    end else begin
      diff_q <= diff_d; num_win_q <= num_win_d; in_win_q <= in_win_d; res_cnt_q <= res_cnt_d;
      beat_q <= beat_d; acc_q <= acc_d; sad_q <= sad_d; win_idx_q <= win_idx_d;
      min_sad_q <= min_sad_d; min_idx_q <= min_idx_d; s1_vld_q <= s1_vld_d; s1_first_q <= s1_first_d;
      s1_last_q <= s1_last_d; out_valid_q <= out_valid_d; done_q <= done_d;
`ifdef SAD_SATURATE_EN
      sat_q <= sat_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sad_out   = sad_q;
  assign bus.win_idx   = win_idx_q;
  assign bus.min_sad   = min_sad_q;
  assign bus.min_idx   = min_idx_q;
  assign done          = done_q;
`ifdef SAD_SATURATE_EN
  assign sat_flag      = sat_q;
`endif
endmodule

// File: tb/tb_sad_stream_engine.sv
// Directed + randomized bench for sad_stream_engine against a window-sum reference model.
module tb_sad_stream_engine;
  localparam int DW = 8, LN = 4, WL = 16, SW = 32, WCW = 8, WLS = 8, SWS = 12;
  typedef logic [LN*DW-1:0] beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, busy, done, start_s, busy_s, done_s;
  logic [WCW-1:0] num_win, num_win_s;
`ifdef SAD_SATURATE_EN
  logic sat_a, sat_s;
`endif

  sad_stream_if #(.DATA_W(DW), .LANES(LN), .SUM_W(SW),  .WIN_CNT_W(WCW)) bus ();
  sad_stream_if #(.DATA_W(DW), .LANES(LN), .SUM_W(SWS), .WIN_CNT_W(WCW)) bus_s ();

  sad_stream_engine #(.DATA_W(DW), .LANES(LN), .WIN_LEN(WL), .SUM_W(SW), .WIN_CNT_W(WCW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_win(num_win), .busy(busy), .done(done), .bus(bus)
`ifdef SAD_SATURATE_EN
    , .sat_flag(sat_a)
`endif
  );
  sad_stream_engine #(.DATA_W(DW), .LANES(LN), .WIN_LEN(WLS), .SUM_W(SWS), .WIN_CNT_W(WCW)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .num_win(num_win_s), .busy(busy_s), .done(done_s), .bus(bus_s)
`ifdef SAD_SATURATE_EN
    , .sat_flag(sat_s)
`endif
  );

  int n_chk = 0, n_err = 0, cyc = 0;
  beat_t qa[$], qb[$];
  longint r_sad[$], r_idx[$], r_min[$], r_midx[$];
  longint e_sad[$], e_min[$], e_midx[$];
  int n_beats = 0, done_cnt = 0, last_acc = 0, last_lat = -1;
  bit saw_stall = 0, ov_prev = 0;
  int n_beats_s = 0, done_cnt_s = 0;
  longint sad_s = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) begin n_beats++; last_acc = cyc; end
    if (bus.in_valid && !bus.in_ready && busy) saw_stall = 1;
    if (bus.out_valid && !ov_prev) last_lat = cyc - last_acc;
    if (bus.out_valid && bus.out_ready) begin
      r_sad.push_back(bus.sad_out); r_idx.push_back(bus.win_idx);
      r_min.push_back(bus.min_sad); r_midx.push_back(bus.min_idx);
    end
    if (done) done_cnt++;
    ov_prev = bus.out_valid;
    if (bus_s.in_valid && bus_s.in_ready) n_beats_s++;
    if (bus_s.out_valid && bus_s.out_ready) sad_s = bus_s.sad_out;
    if (done_s) done_cnt_s++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_job();
    qa.delete(); qb.delete();
    r_sad.delete(); r_idx.delete(); r_min.delete(); r_midx.delete();
    e_sad.delete(); e_min.delete(); e_midx.delete();
  endtask

  task automatic gen_const(input logic [7:0] a8, input logic [7:0] b8, input int n);
    beat_t va, vb;
    for (int l = 0; l < LN; l++) begin va[l*DW +: DW] = a8; vb[l*DW +: DW] = b8; end
    for (int i = 0; i < n; i++) begin qa.push_back(va); qb.push_back(vb); end
  endtask

  // One window where every lane pair differs by exactly d, random sign.
  task automatic gen_diff(input int d);
    beat_t va, vb;
    logic [7:0] x, y;
    for (int i = 0; i < WL; i++) begin
      for (int l = 0; l < LN; l++) begin
        x = 8'($urandom_range(255, d)); y = x - 8'(d);
        if ($urandom % 2 == 0) begin va[l*DW +: DW] = x; vb[l*DW +: DW] = y; end
        else begin va[l*DW +: DW] = y; vb[l*DW +: DW] = x; end
      end
      qa.push_back(va); qb.push_back(vb);
    end
  endtask

  task automatic gen_rand(input int n);
    for (int i = 0; i < n; i++) begin qa.push_back(beat_t'($urandom)); qb.push_back(beat_t'($urandom)); end
  endtask

  // Reference: SAD per window as plain integer sum, then running min keeping earliest on ties.
  task automatic build_exp(input int nw);
    beat_t va, vb;
    longint s, m, mi;
    int av, bv;
    m = 0; mi = 0;
    for (int w = 0; w < nw; w++) begin
      s = 0;
      for (int bt = 0; bt < WL; bt++) begin
        va = qa[w*WL + bt]; vb = qb[w*WL + bt];
        for (int l = 0; l < LN; l++) begin
          av = int'(va[l*DW +: DW]); bv = int'(vb[l*DW +: DW]);
          s += (av > bv) ? av - bv : bv - av;
        end
      end
      s = s % (longint'(1) << SW);
      if (w == 0 || s < m) begin m = s; mi = w; end
      e_sad.push_back(s); e_min.push_back(m); e_midx.push_back(mi);
    end
  endtask

  task automatic do_start(input int n);
    @(posedge clk); #1 start = 1'b1; num_win = WCW'(n);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_beats(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      bus.a_data = qa[i]; bus.b_data = qb[i]; bus.in_valid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        t++;
        if (t > 500) break;
      end
      if (t > 500) begin chk("accept_timeout", 64'(i), 64'(n)); break; end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int snap, input string tag);
    int t = 0;
    while (done_cnt == snap && t < 1000) begin @(negedge clk); t++; end
    chk({tag, "_done_pulses"}, 64'(done_cnt - snap), 64'd1);
  endtask

  task automatic check_results(input string tag, input int nw);
    chk({tag, "_n_results"}, 64'(r_sad.size()), 64'(nw));
    if (r_sad.size() == nw)
      for (int i = 0; i < nw; i++) begin
        chk($sformatf("%s_sad%0d", tag, i),   r_sad[i],  e_sad[i]);
        chk($sformatf("%s_idx%0d", tag, i),   r_idx[i],  64'(i));
        chk($sformatf("%s_min%0d", tag, i),   r_min[i],  e_min[i]);
        chk($sformatf("%s_minix%0d", tag, i), r_midx[i], e_midx[i]);
      end
  endtask

  function automatic longint first_sad(input int i);
    return (r_sad.size() > i) ? r_sad[i] : -1;
  endfunction

  initial begin
    int snap, b0, t;
    longint exp_s;
    rst = 1'b1; start = 1'b0; start_s = 1'b0; num_win = '0; num_win_s = '0;
    bus.in_valid = 1'b0; bus.a_data = '0; bus.b_data = '0; bus.out_ready = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.a_data = '0; bus_s.b_data = '0; bus_s.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0); chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);               chk("rst_done", done, 0);
    chk("rst_sad", bus.sad_out, 0);         chk("rst_min_sad", bus.min_sad, 0);
    @(posedge clk); #1 rst = 1'b0;

    // single window, constant difference 12 on every lane
    clear_job(); gen_const(8'h10, 8'h04, WL); build_exp(1);
    snap = done_cnt; b0 = n_beats;
    do_start(1); send_beats(WL); wait_done(snap, "t1");
    check_results("t1", 1);
    chk("t1_sad_768", first_sad(0), 768);
    chk("t1_latency", 64'(last_lat), 2);
    chk("t1_beats", 64'(n_beats - b0), WL);
    chk("t1_busy_after", busy, 0);

    // three windows, lane differences 5/2/2, tie keeps index 1
    clear_job(); gen_diff(5); gen_diff(2); gen_diff(2); build_exp(3);
    snap = done_cnt;
    do_start(3); send_beats(3*WL); wait_done(snap, "t2");
    check_results("t2", 3);
    chk("t2_sad0_320", first_sad(0), 320);
    chk("t2_sad1_128", first_sad(1), 128);
    chk("t2_sad2_128", first_sad(2), 128);
    repeat (3) @(negedge clk);
    chk("t2_min_held", bus.min_sad, 128);
    chk("t2_minidx_held", bus.min_idx, 1);

    // consumer back-pressure for 40 cycles across two windows
    clear_job(); gen_rand(2*WL); build_exp(2);
    snap = done_cnt; saw_stall = 0;
    do_start(2);
    fork
      send_beats(2*WL);
      begin bus.out_ready = 1'b0; repeat (40) @(posedge clk); #1 bus.out_ready = 1'b1; end
    join
    wait_done(snap, "t3");
    check_results("t3", 2);
    chk("t3_in_ready_dropped", saw_stall, 1);

    // reset in the middle of a window, then a fresh job
    clear_job(); gen_rand(WL);
    snap = done_cnt;
    do_start(1); send_beats(7);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t4_busy", busy, 0);           chk("t4_in_ready", bus.in_ready, 0);
    chk("t4_out_valid", bus.out_valid, 0); chk("t4_sad", bus.sad_out, 0);
    chk("t4_min_sad", bus.min_sad, 0); chk("t4_no_done", 64'(done_cnt - snap), 0);
    @(posedge clk); #1 rst = 1'b0;
    clear_job(); gen_rand(WL); build_exp(1);
    snap = done_cnt;
    do_start(1); send_beats(WL); wait_done(snap, "t4b");
    check_results("t4b", 1);

    // start while busy and beats offered during DRAIN are both ignored
    clear_job(); gen_rand(2*WL); build_exp(2);
    snap = done_cnt; b0 = n_beats;
    do_start(2);
    fork
      send_beats(2*WL);
      begin repeat (5) @(posedge clk); #1 start = 1'b1; num_win = 8'd7; @(posedge clk); #1 start = 1'b0; end
    join
    bus.in_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1 bus.a_data = beat_t'($urandom); end
    bus.in_valid = 1'b0;
    wait_done(snap, "t5");
    check_results("t5", 2);
    chk("t5_beats", 64'(n_beats - b0), 2*WL);
    repeat (3) @(negedge clk);
    chk("t5_idle_after", busy, 0);

    // num_win = 0 runs one window
    clear_job(); gen_rand(WL); build_exp(1);
    snap = done_cnt; b0 = n_beats;
    do_start(0); send_beats(WL); wait_done(snap, "t6");
    check_results("t6", 1);
    chk("t6_beats", 64'(n_beats - b0), WL);

    // four random windows under random consumer readiness
    clear_job(); gen_rand(4*WL); build_exp(4);
    snap = done_cnt;
    do_start(4);
    fork
      send_beats(4*WL);
      for (int k = 0; k < 600 && done_cnt == snap; k++) begin
        @(posedge clk); #1 bus.out_ready = ($urandom % 2 == 0);
      end
    join
    bus.out_ready = 1'b1;
    wait_done(snap, "t7");
    check_results("t7", 4);

    // small accumulator stress on the second instance
`ifdef SAD_SATURATE_EN
    exp_s = 4095;
`else
    exp_s = 4064;
`endif
    snap = done_cnt_s;
    @(posedge clk); #1 start_s = 1'b1; num_win_s = 8'd1;
    @(posedge clk); #1 start_s = 1'b0;
    bus_s.a_data = '1; bus_s.b_data = '0; bus_s.in_valid = 1'b1;
    t = 0;
    while (n_beats_s < WLS && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1 bus_s.in_valid = 1'b0;
    t = 0;
    while (done_cnt_s == snap && t < 200) begin @(negedge clk); t++; end
    chk("ts_done_pulses", 64'(done_cnt_s - snap), 1);
    chk("ts_beats", 64'(n_beats_s), WLS);
    chk("ts_sad", sad_s, exp_s);
`ifdef SAD_SATURATE_EN
    chk("ts_sat_flag", sat_s, 1);
    chk("main_sat_flag", sat_a, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
